ebpf_alu32_shift_stage: RTL
===========================

Name: ebpf_alu32_shift_stage

Overview:
- Two-stage pipelined execute stage for eBPF ALU32 shift instructions (LSH, RSH, ARSH).
- Sits directly upstream of the team's combinational 32-bit logical right shifter.
  - Stage 1 selects and masks the operands and drives them into the shifter.
  - Stage 2 captures the shifter result, applies the ARSH sign fill or the internal LSH path, and zero-extends to 64 bits for writeback.
- Valid/ready handshake on both sides; full throughput of one op per cycle.

Parameters:
- REG_IDX_W, 4, width of the destination register index carried with each op.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous pipeline flush; drops all in-flight ops
- in_valid  in  1  op offered
- in_ready  out  1  stage can accept the op this cycle
- in_op  in  2  00=LSH, 01=RSH, 10=ARSH, 11=illegal
- in_src_imm  in  1  1: shift amount from in_imm; 0: from in_src
- in_dst  in  64  destination register value; bits [31:0] are the operand
- in_src  in  64  source register value
- in_imm  in  32  instruction immediate
- in_rd  in  REG_IDX_W  destination register index
- rsh_a  out  32  operand to the external right shifter (stage-1 register)
- rsh_b  out  32  shift amount to the external shifter, always {27'b0, amt[4:0]}
- rsh_c  in  32  external shifter result (combinational from rsh_a and rsh_b)
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_data  out  64  result, zero-extended: {32'b0, res32}
- out_rd  out  REG_IDX_W  destination index
- out_illegal  out  1  op was illegal (in_op=11)

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - s1_valid=0, s2_valid=0, out_valid=0
  - out_data=0, out_rd=0, out_illegal=0
  - rsh_a=0, rsh_b=0
  - in_ready is 1 in the cycle after reset.
- Flush behaves like reset on the valid bits only; data registers need not clear. Reset or flush mid-operation discards every in-flight op, and no partial output is produced.
- Advance conditions:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
  - Accept = in_valid && in_ready.
- Stage 1, on accept:
  - Latch op, rd and a = in_dst[31:0].
  - Latch amt = (in_src_imm ? in_imm[4:0] : in_src[4:0]). Upper bits are ignored (mod-32 per eBPF).
- rsh_a and rsh_b come from the stage-1 registers. For LSH and illegal ops they still carry the latched values; the result ignores them.
- Stage 2 captures on s1_valid && s2_adv:
  - LSH: res = a << amt
  - RSH: res = rsh_c
  - ARSH: res = rsh_c | (a[31] ? ~(32'hFFFF_FFFF >> amt) : 0)
  - Illegal: res = 0, out_illegal = 1
- Latency: out_valid is asserted 2 cycles after the accept edge when there is no backpressure.
- Ordering: strictly in order, with no reordering or dropping.
- Backpressure:
  - While out_valid && !out_ready, out_data, out_rd and out_illegal are held stable.
  - At most 2 ops are buffered; in_ready=0 when both stages are full and out_ready=0.
- Simultaneous events: out_ready together with a full pipeline and in_valid gives shift-through in one cycle, with no bubble.
- Priority: rst > flush > normal.
- amt=0: the result equals a for all ops.
- amt=31, ARSH with a[31]=1: result is 0xFFFF_FFFF.

Test Plan:
- RSH, in_src_imm=1, in_imm=4, in_dst=0xFFFF_FFFF_8000_0000 -> out_data=0x0000_0000_0800_0000, out_valid 2 cycles after accept.
- ARSH, same operands -> out_data=0x0000_0000_F800_0000. ARSH with in_imm=31 -> 0x0000_0000_FFFF_FFFF.
- LSH, in_src_imm=0, in_src=0x25 (37 masked to 5), in_dst=0x1 -> out_data=0x20. LSH with in_dst=0x8000_0001 and amount 1 -> 0x0000_0000_0000_0002.
- Back-to-back RSH by 1 of 0x10, 0x20, 0x40 with out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts, and out_data holds 0x08.
  - After out_ready=1, the outputs are 0x08, 0x10 and 0x20 on consecutive cycles.
- in_op=11 with arbitrary operands -> out_illegal=1, out_data=0, out_rd passed through. The next legal op has out_illegal=0.
- Two ops in flight, then flush=1 (and separately rst=1) -> next cycle out_valid=0, no results emerge, in_ready=1.

Source files
------------

// File: rtl/ebpf_alu32_shift_stage_if.sv
// rtl/ebpf_alu32_shift_stage_if.sv - op/result/shifter bundle for the eBPF ALU32 shift stage
//
// Purpose: groups the upstream op handshake, the external right-shifter
// connection and the downstream result handshake of ebpf_alu32_shift_stage.
//
// Signals:
//   in_valid / in_ready        op handshake (in_ready driven by the stage)
//   in_op                      00=LSH 01=RSH 10=ARSH 11=illegal
//   in_src_imm                 1: amount from in_imm, 0: from in_src
//   in_dst, in_src, in_imm     operands (only low bits are consumed)
//   in_rd                      destination register index
//   rsh_a, rsh_b               operand/amount driven to the external shifter
//   rsh_c                      shifter result returned to the stage
//   out_valid / out_ready      result handshake (out_ready driven by consumer)
//   out_data, out_rd           zero-extended result and destination index
//   out_illegal                op was illegal
//
// Modports: slave = the shift stage, master = its environment.

interface ebpf_alu32_shift_stage_if #(
  parameter int REG_IDX_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_op;
  logic                 in_src_imm;
  logic [63:0]          in_dst;
  logic [63:0]          in_src;
  logic [31:0]          in_imm;
  logic [REG_IDX_W-1:0] in_rd;

  logic [31:0]          rsh_a;
  logic [31:0]          rsh_b;
  logic [31:0]          rsh_c;

  logic                 out_valid;
  logic                 out_ready;
  logic [63:0]          out_data;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 out_illegal;

  modport slave (
    input  in_valid, in_op, in_src_imm, in_dst, in_src, in_imm, in_rd,
    output in_ready,
    output rsh_a, rsh_b,
    input  rsh_c,
    output out_valid, out_data, out_rd, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_src_imm, in_dst, in_src, in_imm, in_rd,
    input  in_ready,
    input  rsh_a, rsh_b,
    output rsh_c,
    input  out_valid, out_data, out_rd, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/ebpf_alu32_shift_stage.sv
// rtl/ebpf_alu32_shift_stage.sv - two-stage eBPF ALU32 LSH/RSH/ARSH execute stage
//
// Purpose: stage 1 latches and masks the operands and presents them to an
// external combinational 32-bit logical right shifter; stage 2 captures the
// shifter output, applies the ARSH sign fill (or computes LSH locally) and
// presents the result zero-extended to 64 bits. One op per cycle, in order.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   flush  synchronous flush; drops every in-flight op
//   bus    ebpf_alu32_shift_stage_if.slave (op in, shifter link, result out)

module ebpf_alu32_shift_stage #(
  parameter int REG_IDX_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  ebpf_alu32_shift_stage_if.slave bus
);

  typedef enum logic [1:0] {
    OP_LSH  = 2'b00,
    OP_RSH  = 2'b01,
    OP_ARSH = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  // stage 1
  logic                 s1_valid;
  op_e                  s1_op;
  logic [REG_IDX_W-1:0] s1_rd;
  logic [31:0]          s1_a;
  logic [4:0]           s1_amt;

  // stage 2 (doubles as the output register)
  logic                 s2_valid;
  logic [31:0]          s2_res;
  logic [REG_IDX_W-1:0] s2_rd;
  logic                 s2_ill;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 accept;
  logic [4:0]           in_amt;
  logic [31:0]          res;
  logic                 res_ill;

  // Bits outside the architectural operand/amount fields are ignored.
  logic                 unused_in_bits;
  assign unused_in_bits = ^{bus.in_dst[63:32], bus.in_src[63:5], bus.in_imm[31:5]};

  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign accept = bus.in_valid && s1_adv;

  assign bus.in_ready = s1_adv;

  // eBPF ALU32 shifts are mod 32, so only the low five bits matter.
  assign in_amt = bus.in_src_imm ? bus.in_imm[4:0] : bus.in_src[4:0];

  assign bus.rsh_a = s1_a;
  assign bus.rsh_b = {27'b0, s1_amt};

  assign bus.out_valid   = s2_valid;
  assign bus.out_data    = {32'b0, s2_res};
  assign bus.out_rd      = s2_rd;
  assign bus.out_illegal = s2_ill;

  // Result select. The external shifter only does logical right shifts;
  // ARSH ORs in the vacated high bits when the operand is negative, and LSH
  // never uses the shifter. With amt=0 the fill mask is zero, so ARSH
  // degenerates to the plain operand like the other ops.
  always_comb begin
    res     = '0;
    res_ill = 1'b0;
    case (s1_op)
      OP_LSH:  res = s1_a << s1_amt;
      OP_RSH:  res = bus.rsh_c;
      OP_ARSH: res = bus.rsh_c | (s1_a[31] ? ~(32'hFFFF_FFFF >> s1_amt) : 32'h0);
      OP_ILL: begin
        res     = '0;
        res_ill = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_LSH;
      s1_rd    <= '0;
      s1_a     <= '0;
      s1_amt   <= '0;
      s2_valid <= 1'b0;
      s2_res   <= '0;
      s2_rd    <= '0;
      s2_ill   <= 1'b0;
    end else begin
      if (flush) begin
        // Data registers are left alone; only the valids matter.
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (s2_adv) begin
          s2_valid <= s1_valid;
        end
        if (s1_adv) begin
          s1_valid <= accept;
        end
      end

      if (s1_valid && s2_adv && !flush) begin
        s2_res <= res;
        s2_rd  <= s1_rd;
        s2_ill <= res_ill;
      end

      if (accept && !flush) begin
        s1_op  <= op_e'(bus.in_op);
        s1_rd  <= bus.in_rd;
        s1_a   <= bus.in_dst[31:0];
        s1_amt <= in_amt;
      end
    end
  end

endmodule
